// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants, decoded op classes and immediate formats.
package core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
   localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
   localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

   // OPC_NONE marks an empty or illegal slot so a cleared bundle reads as all zeros.
   typedef enum logic [3:0] {
      OPC_NONE     = 4'd0,
      OPC_LUI      = 4'd1,
      OPC_AUIPC    = 4'd2,
      OPC_JAL      = 4'd3,
      OPC_JALR     = 4'd4,
      OPC_BRANCH   = 4'd5,
      OPC_LOAD     = 4'd6,
      OPC_STORE    = 4'd7,
      OPC_OP_IMM   = 4'd8,
      OPC_OP       = 4'd9,
      OPC_MISC_MEM = 4'd10,
      OPC_SYSTEM   = 4'd11
   } opclass_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction for the I/S/B/U/J formats; IMM_NONE yields zero.
module imm_gen
   import core_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (imm_type)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready handshake, regfile address mux, operand capture, registered decode bundle.
// Optional write-through bypass for same-cycle regfile writes is enabled by defining DECODE_BYPASS_EN.
module decode_stage
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      r0addr,
   output logic [4:0]      r1addr,
   input  logic [XLEN-1:0] r0data,
   input  logic [XLEN-1:0] r1data,
   input  logic            wb_wren,
   input  logic [4:0]      wb_waddr,
   input  logic [XLEN-1:0] wb_wdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_val,
   output logic [XLEN-1:0] out_rs2_val,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output opclass_e        out_opclass,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic            out_illegal
);

   logic            valid_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] pc_q;
   logic            accept;
   logic [XLEN-1:0] rs1_raw;
   logic [XLEN-1:0] rs2_raw;
   opclass_e        opclass;
   imm_type_e       imm_type;
   logic            illegal;

   assign in_ready = !rst && !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         instr_q <= in_instr;
         pc_q    <= in_pc;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Re-reading the held indices every non-accept cycle keeps a stalled bundle's operands current.
   always_comb begin
      r0addr = '0;
      r1addr = '0;
      if (rst) begin
         r0addr = '0;
         r1addr = '0;
      end else if (accept) begin
         r0addr = in_instr[19:15];
         r1addr = in_instr[24:20];
      end else begin
         r0addr = instr_q[19:15];
         r1addr = instr_q[24:20];
      end
   end

`ifdef DECODE_BYPASS_EN
   logic            hit0_q;
   logic            hit1_q;
   logic [XLEN-1:0] wdata0_q;
   logic [XLEN-1:0] wdata1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit0_q   <= 1'b0;
         hit1_q   <= 1'b0;
         wdata0_q <= '0;
         wdata1_q <= '0;
      end else begin
         hit0_q   <= wb_wren && (wb_waddr == r0addr) && (r0addr != '0);
         hit1_q   <= wb_wren && (wb_waddr == r1addr) && (r1addr != '0);
         wdata0_q <= wb_wdata;
         wdata1_q <= wb_wdata;
      end
   end

   assign rs1_raw = hit0_q ? wdata0_q : r0data;
   assign rs2_raw = hit1_q ? wdata1_q : r1data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_wren, wb_waddr, wb_wdata};
   assign rs1_raw   = r0data;
   assign rs2_raw   = r1data;
`endif

   always_comb begin
      opclass  = OPC_NONE;
      imm_type = IMM_NONE;
      illegal  = 1'b0;
      case (instr_q[6:0])
         OPCODE_LUI:      begin opclass = OPC_LUI;      imm_type = IMM_U; end
         OPCODE_AUIPC:    begin opclass = OPC_AUIPC;    imm_type = IMM_U; end
         OPCODE_JAL:      begin opclass = OPC_JAL;      imm_type = IMM_J; end
         OPCODE_JALR:     begin opclass = OPC_JALR;     imm_type = IMM_I; end
         OPCODE_BRANCH:   begin opclass = OPC_BRANCH;   imm_type = IMM_B; end
         OPCODE_LOAD:     begin opclass = OPC_LOAD;     imm_type = IMM_I; end
         OPCODE_STORE:    begin opclass = OPC_STORE;    imm_type = IMM_S; end
         OPCODE_OP_IMM:   begin opclass = OPC_OP_IMM;   imm_type = IMM_I; end
         OPCODE_OP:       begin opclass = OPC_OP;       imm_type = IMM_NONE; end
         OPCODE_MISC_MEM: begin opclass = OPC_MISC_MEM; imm_type = IMM_I; end
         OPCODE_SYSTEM:   begin opclass = OPC_SYSTEM;   imm_type = IMM_I; end
         default:         illegal = 1'b1;
      endcase
   end

   imm_gen u_imm_gen (
      .instr    (instr_q),
      .imm_type (imm_type),
      .imm      (out_imm)
   );

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_rs1      = instr_q[19:15];
   assign out_rs2      = instr_q[24:20];
   assign out_rd       = instr_q[11:7];
   assign out_funct3   = instr_q[14:12];
   assign out_funct7b5 = instr_q[30];
   assign out_opclass  = opclass;
   // A cleared (all-zero) slot would otherwise decode as illegal.
   assign out_illegal  = valid_q && illegal;
   assign out_rs1_val  = (out_rs1 == '0) ? '0 : rs1_raw;
   assign out_rs2_val  = (out_rs2 == '0) ? '0 : rs2_raw;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a behavioural synchronous-read register file.
module tb_decode_stage;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, r0data, r1data, wb_wdata;
   logic [4:0]  r0addr, r1addr, wb_waddr, out_rs1, out_rs2, out_rd;
   logic        wb_wren, out_funct7b5, out_illegal;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [2:0]  out_funct3;
   opclass_e    out_opclass;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .r0addr(r0addr), .r1addr(r1addr), .r0data(r0data), .r1data(r1data),
      .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_opclass(out_opclass), .out_funct3(out_funct3),
      .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
   );

   // Raw storage (x0 writable) so the stage's own x0 masking is what gets exercised.
   logic [31:0] regs [32];
   always @(posedge clk) begin
      r0data <= regs[r0addr];
      r1data <= regs[r1addr];
      if (wb_wren) regs[wb_waddr] <= wb_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [3:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic        ill;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{32'h0020A423, 32'h00000008, OPC_STORE,    3'd2, 1'b0, 1'b0};
      vecs[1]  = '{32'hFE208EE3, 32'hFFFFFFFC, OPC_BRANCH,   3'd0, 1'b1, 1'b0};
      vecs[2]  = '{32'h123453B7, 32'h12345000, OPC_LUI,      3'd5, 1'b0, 1'b0};
      vecs[3]  = '{32'hFF9FF0EF, 32'hFFFFFFF8, OPC_JAL,      3'd7, 1'b1, 1'b0};
      vecs[4]  = '{32'h402081B3, 32'h00000000, OPC_OP,       3'd0, 1'b1, 1'b0};
      vecs[5]  = '{32'h00000010, 32'h00000000, OPC_NONE,     3'd0, 1'b0, 1'b1};
      vecs[6]  = '{32'h00001297, 32'h00001000, OPC_AUIPC,    3'd1, 1'b0, 1'b0};
      vecs[7]  = '{32'hFFC0A283, 32'hFFFFFFFC, OPC_LOAD,     3'd2, 1'b1, 1'b0};
      vecs[8]  = '{32'h010100E7, 32'h00000010, OPC_JALR,     3'd0, 1'b0, 1'b0};
      vecs[9]  = '{32'h0FF0000F, 32'h000000FF, OPC_MISC_MEM, 3'd0, 1'b0, 1'b0};
      vecs[10] = '{32'h00000073, 32'h00000000, OPC_SYSTEM,   3'd0, 1'b0, 1'b0};
      vecs[11] = '{32'h00500313, 32'h00000005, OPC_OP_IMM,   3'd0, 1'b0, 1'b0};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h100;
      out_ready = 1'b1; wb_wren = 1'b0; wb_waddr = '0; wb_wdata = '0;

      // Reset
      tick(); tick();
      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_r0addr",   32'(r0addr), 32'd0);
      check("rst_r1addr",   32'(r1addr), 32'd0);
      check("rst_pc",       out_pc, 32'd0);
      check("rst_imm",      out_imm, 32'd0);
      check("rst_illegal",  32'(out_illegal), 32'd0);
      check("rst_opclass",  32'(out_opclass), 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      #1 check("rel_in_ready", 32'(in_ready), 32'd1);

      // Preload x1=0x10, x2=0x20
      wb_wren = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h10; tick();
      wb_waddr = 5'd2; wb_wdata = 32'h20; tick();
      wb_wren = 1'b0;

      // Basic: addi x5,x1,-1
      in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h100;
      #1 check("basic_r0addr", 32'(r0addr), 32'd1);
      tick(); in_valid = 1'b0;
      check("basic_valid",   32'(out_valid), 32'd1);
      check("basic_rs1_val", out_rs1_val, 32'h10);
      check("basic_imm",     out_imm, 32'hFFFFFFFF);
      check("basic_rd",      32'(out_rd), 32'd5);
      check("basic_rs1",     32'(out_rs1), 32'd1);
      check("basic_opclass", 32'(out_opclass), 32'(OPC_OP_IMM));
      check("basic_pc",      out_pc, 32'h100);
      check("basic_illegal", 32'(out_illegal), 32'd0);
      tick();
      check("basic_drain", 32'(out_valid), 32'd0);

      // Same-cycle write of x1 while add x3,x1,x2 is accepted
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h104;
      wb_wren = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h55;
      tick(); in_valid = 1'b0; wb_wren = 1'b0;
      check("byp_rs1_val", out_rs1_val, BYP ? 32'h55 : 32'h10);
      check("byp_rs2_val", out_rs2_val, 32'h20);
      check("byp_opclass", 32'(out_opclass), 32'(OPC_OP));
      check("byp_imm",     out_imm, 32'd0);
      check("byp_rd",      32'(out_rd), 32'd3);
      tick();

      // Stall with write of x2 in stall cycle 1
      in_valid = 1'b1; in_instr = 32'h00208233; in_pc = 32'h108;
      tick();
      out_ready = 1'b0; in_instr = 32'hFFF08293; in_pc = 32'h200;
      wb_wren = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'hA;
      #1;
      check("st1_in_ready", 32'(in_ready), 32'd0);
      check("st1_rs2_val",  out_rs2_val, 32'h20);
      check("st1_rs1_val",  out_rs1_val, 32'h55);
      check("st1_r1addr",   32'(r1addr), 32'd2);
      tick(); wb_wren = 1'b0;
      check("st2_rs2_val",  out_rs2_val, BYP ? 32'hA : 32'h20);
      check("st2_in_ready", 32'(in_ready), 32'd0);
      check("st2_rd",       32'(out_rd), 32'd4);
      tick();
      check("st3_rs2_val",  out_rs2_val, 32'hA);
      check("st3_pc",       out_pc, 32'h108);
      check("st3_valid",    32'(out_valid), 32'd1);
      check("st3_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("st4_rs2_val",  out_rs2_val, 32'hA);
      check("st4_rd",       32'(out_rd), 32'd4);
      out_ready = 1'b1; in_valid = 1'b0;
      tick();
      check("st_drain", 32'(out_valid), 32'd0);

      // x0 protection: addi x6,x0,5 with a write to x0
      in_valid = 1'b1; in_instr = 32'h00500313; in_pc = 32'h10C; out_ready = 1'b0;
      wb_wren = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFF;
      tick(); in_valid = 1'b0; wb_wren = 1'b0;
      check("x0_rs1_val",  out_rs1_val, 32'd0);
      check("x0_imm",      out_imm, 32'd5);
      check("x0_rd",       32'(out_rd), 32'd6);
      tick();
      check("x0_reread",   out_rs1_val, 32'd0);
      out_ready = 1'b1;
      tick();

      // Reset in the middle of a stall
      in_valid = 1'b1; in_instr = 32'h00208233; in_pc = 32'h300; out_ready = 1'b0;
      tick(); in_valid = 1'b0;
      check("rstst_valid_pre", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rstst_in_ready", 32'(in_ready), 32'd0);
      check("rstst_r1addr",   32'(r1addr), 32'd0);
      tick(); rst = 1'b0;
      check("rstst_valid",   32'(out_valid), 32'd0);
      check("rstst_pc",      out_pc, 32'd0);
      check("rstst_rd",      32'(out_rd), 32'd0);
      check("rstst_rs2_val", out_rs2_val, 32'd0);
      out_ready = 1'b1;

      // Back-to-back decode table at full throughput
      foreach (vecs[i]) begin
         in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i) * 4;
         #1 check($sformatf("tp%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
         check($sformatf("tp%0d_valid", i),   32'(out_valid), 32'd1);
         check($sformatf("tp%0d_pc", i),      out_pc, 32'h1000 + 32'(i) * 4);
         check($sformatf("tp%0d_imm", i),     out_imm, vecs[i].imm);
         check($sformatf("tp%0d_opclass", i), 32'(out_opclass), 32'(vecs[i].opc));
         check($sformatf("tp%0d_funct3", i),  32'(out_funct3), 32'(vecs[i].f3));
         check($sformatf("tp%0d_f7b5", i),    32'(out_funct7b5), 32'(vecs[i].f7));
         check($sformatf("tp%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      end
      in_valid = 1'b0;
      tick();
      check("tp_drain", 32'(out_valid), 32'd0);

      // Illegal all-zero word, then flush while stalled
      in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h400;
      tick(); in_valid = 1'b0;
      check("ill_illegal", 32'(out_illegal), 32'd1);
      check("ill_valid",   32'(out_valid), 32'd1);
      check("ill_opclass", 32'(out_opclass), 32'(OPC_NONE));
      check("ill_imm",     out_imm, 32'd0);
      out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500313; in_pc = 32'h500;
      #1 check("fl_in_ready", 32'(in_ready), 32'd0);
      tick(); flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_pc",    out_pc, 32'h400);
      tick();
      check("fl_valid_after", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
